// File: rtl/axi_lite_bram_slave.sv
// ============================================================================
// axi_lite_bram_slave: AXI4-Lite slave in front of a single-port, byte-writable
// synchronous-read word array, with SLVERR for out-of-range accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_lite_bram_slave #(
    parameter int                         DEPTH         = 4096,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS  = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready
);

    localparam int                     c_IDX_W  = $clog2(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] c_SPAN   = (ADDRESS_WIDTH+1)'(DEPTH) << 2;
    localparam logic [1:0]             c_OKAY   = 2'b00;
    localparam logic [1:0]             c_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_DATA  = 2'd2,
        R_RESP  = 2'd3
    } r_state_t;

    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        logic [ADDRESS_WIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDRESS};
        return (a >= BASE_ADDRESS) && (off < c_SPAN);
    endfunction

    function automatic logic [c_IDX_W-1:0] addr_idx(input logic [ADDRESS_WIDTH-1:0] a);
        return c_IDX_W'((a - BASE_ADDRESS) >> 2);
    endfunction

    logic [31:0]              mem_q [DEPTH];
    logic [31:0]              mem_rd_q;

    logic                     aw_held_q, w_held_q, bvalid_q;
    logic [1:0]               bresp_q;
    logic [ADDRESS_WIDTH-1:0] awaddr_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;

    r_state_t                 r_state_q;
    logic [ADDRESS_WIDTH-1:0] araddr_q;
    logic                     rvalid_q;
    logic [1:0]               rresp_q;
    logic [31:0]              rdata_q;

    logic                     w_commit, w_aw_ok, w_ar_ok, w_mem_we, w_mem_re;
    logic [c_IDX_W-1:0]       w_mem_addr;
    logic                     w_unused;

    assign w_unused = ^{awprot, arprot};

    assign awready  = !reset && !aw_held_q && !bvalid_q;
    assign wready   = !reset && !w_held_q  && !bvalid_q;
    assign arready  = !reset && (r_state_q == R_IDLE);

    // bvalid blocks a second commit of the same held pair until the B handshake.
    assign w_commit = aw_held_q && w_held_q && !bvalid_q;
    assign w_aw_ok  = addr_ok(awaddr_q);
    assign w_ar_ok  = addr_ok(araddr_q);
    assign w_mem_we = w_commit && w_aw_ok;
    assign w_mem_re = (r_state_q == R_ISSUE) && !w_commit && w_ar_ok;
    assign w_mem_addr = w_commit ? addr_idx(awaddr_q) : addr_idx(araddr_q);

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[w_mem_addr][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
        if (w_mem_re) mem_rd_q <= mem_q[w_mem_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= c_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= awaddr;
            end
            if (wvalid && wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= wdata;
                wstrb_q  <= wstrb;
            end
            if (w_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_aw_ok ? c_OKAY : c_SLVERR;
            end else if (bvalid_q && bready) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= c_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        araddr_q  <= araddr;
                        r_state_q <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    // A same-cycle write commit owns the port; retry next cycle.
                    if (!w_commit) r_state_q <= R_DATA;
                end
                R_DATA: begin
                    rvalid_q  <= 1'b1;
                    rresp_q   <= w_ar_ok ? c_OKAY : c_SLVERR;
                    rdata_q   <= w_ar_ok ? mem_rd_q : 32'h0;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

endmodule

`default_nettype wire

// File: doc/axi_lite_bram_slave.md
Name: axi_lite_bram_slave

Overview:
AXI4-Lite slave that terminates the BRAM-side AXI-Lite link produced by the system bus-to-AXI-Lite bridge. It stores data in an internal single-port, byte-writable, synchronous-read word array. It handles independent AW/W/B and AR/R channels, arbitrates the single memory port, and reports out-of-range accesses with SLVERR.

Parameters:
DEPTH, 4096, number of 32-bit words; power of two, at least 2
ADDRESS_WIDTH, 32, width of araddr/awaddr
BASE_ADDRESS, 0, byte address of word 0; must be aligned to DEPTH*4

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
awaddr  input  ADDRESS_WIDTH  write address
awprot  input  3  ignored
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i]
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response: 00 OKAY, 10 SLVERR
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  ADDRESS_WIDTH  read address
arprot  input  3  ignored
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response: 00 OKAY, 10 SLVERR
rvalid  output  1  read data valid
rready  input  1  read data ready

Behaviour:
- Reset, asynchronous and immediate: bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0. awready, wready and arready are forced to 0 while reset is high. All captured-address and captured-data flags clear. Array contents are not reset.
- Range check: in range iff BASE_ADDRESS <= addr < BASE_ADDRESS+DEPTH*4.
- Word index: (addr-BASE_ADDRESS)>>2. addr[1:0] is ignored.
- Write path:
  - awready=1 while no AW is held and bvalid=0.
  - wready=1 while no W is held and bvalid=0.
  - AW and W are accepted in any order, or in the same cycle, and are held in registers.
  - Commit cycle: the first cycle in which both AW and W are held. In range: the array is written under wstrb, with wstrb=0000 meaning no change, and bresp=00. Out of range: the array is untouched and bresp=10.
  - bvalid rises the cycle after commit and is held until bready. The held flags clear on the B handshake.
  - Minimum latency: AW and W in cycle 0, commit in cycle 1, bvalid in cycle 2.
- Read path FSM:
  - R_IDLE: arready=1. On an AR handshake, capture the address and go to R_ISSUE.
  - R_ISSUE: if the memory port is free, issue the array read and go to R_DATA. Otherwise stay.
  - R_DATA: rdata takes the array output; rresp=00, or 10 with rdata=0 if out of range. rvalid=1 from the next cycle. Go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are stable until rready, then return to R_IDLE.
  - arready=0 in every state other than R_IDLE.
  - Minimum latency: AR in cycle 0, rvalid in cycle 3.
- Port arbitration: a write commit has priority over R_ISSUE in the same cycle, and the read retries on the next cycle. A read that follows a write to the same word returns the new data.
- Out-of-range accesses never issue to the array, but still take one R_ISSUE cycle.
- Reads and writes proceed concurrently otherwise. At most one outstanding transaction per direction.
- Backpressure: bvalid and rvalid are never withdrawn before their handshake, and their payload never changes while valid.
- Reset mid-transaction: the transaction is dropped with no response. A write whose commit edge preceded reset stays in the array.

Test Plan:
1. Write 0xDEADBEEF with wstrb=1111 to BASE+0x10, with AW and W in the same cycle, then read BASE+0x10 -> bresp=00 at cycle 2; rdata=0xDEADBEEF, rresp=00.
2. Write 0x11223344 to word 5, then write 0xAABBCCDD with wstrb=0101 to word 5, then read word 5 -> rdata=0x11BB33DD.
3. Present W 3 cycles before AW; hold bready=0 for 4 cycles -> awready and wready stay 0 while bvalid=1; bvalid stays high, bresp stable; one B handshake occurs.
4. Write to and read from BASE+DEPTH*4 -> bresp=10; rresp=10, rdata=0; word 0 and word DEPTH-1 are unchanged.
5. A commit to word 7 collides with R_ISSUE for word 7 (old value 0x1, new value 0x2) -> the read is delayed by one cycle and returns 0x2.
6. Assert reset while rvalid=1 and rready=0 -> rvalid=0 immediately; arready=1 on the first cycle after release; earlier array writes still read back correctly.
